idu_decode_stage: RTL and testbench
===================================

# idu_decode_stage

Instruction decode stage sitting directly downstream of the fetch unit. It accepts one (inst, pc) pair per valid/ready handshake, decodes RV32I base integer instructions into register indices, sign-extended immediate, ALU operation and instruction-class flags, and holds the result in a single output register until the execute stage accepts it. It also supports a flush from branch/jump redirect and flags illegal encodings.

## Interface
Parameters:
- ADDR_W, 32, PC width
- DATA_W, 32, instruction/immediate width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- prev_valid  in  1  fetch stage presents a valid instruction
- ready_o  out  1  stage can accept a new instruction this cycle
- inst  in  DATA_W  instruction word from fetch
- pc  in  ADDR_W  PC of inst
- flush  in  1  discard held and incoming instruction (redirect)
- valid_o  out  1  decoded bundle valid
- next_ready  in  1  execute stage accepts the bundle
- pc_o  out  ADDR_W  PC of decoded instruction
- inst_o  out  DATA_W  raw instruction word
- rs1_o, rs2_o, rd_o  out  5 each  register indices (0 when unused)
- imm_o  out  DATA_W  sign-extended immediate
- alu_op_o  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_IMM
- funct3_o  out  3  inst[14:12], for load/store/branch width and compare type
- rd_we_o  out  1  writes rd (forced 0 when rd==0)
- alu_src_imm_o  out  1  ALU operand B is imm
- is_load_o, is_store_o, is_branch_o, is_jal_o, is_jalr_o, is_auipc_o, is_system_o  out  1 each  class flags
- illegal_o  out  1  unrecognised opcode/funct combination

## Operation
- Output register holds all *_o fields; fields change only on a load or on reset.
- Load condition: prev_valid & ready_o & !flush.
- ready_o = !valid_o | next_ready (combinational; single-entry pipe register with pass-through on accept).
- Immediate formats: I (OP-IMM, LOAD, JALR, SYSTEM), S (STORE), B (BRANCH, bit0=0), U (LUI/AUIPC, low 12 zero), J (JAL, bit0=0); R-type imm=0.
- alu_op: OP/OP-IMM from funct3 with inst[30] selecting SUB (OP only) / SRA; SLLI/SRLI/SRAI with inst[31:25] not 0000000/0100000 -> illegal. LOAD/STORE/AUIPC/JAL/JALR -> ADD; BRANCH -> SUB; LUI -> PASS_IMM.
- rs1 used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR; rs2 by OP, STORE, BRANCH; unused indices output as 0.
- rd_we for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR; SYSTEM rd_we only for CSR funct3≠0.
- Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111 (FENCE, decoded as NOP: rd_we=0), 1110011. Also illegal: inst[1:0]≠11, BRANCH funct3 010/011, LOAD funct3 011/110/111, STORE funct3 ≥011, JALR funct3≠0. Illegal instructions still pass through with illegal_o=1, rd_we=0, all other class flags 0.

## Timing
- Reset: valid_o=0, all other outputs 0; ready_o=1 the cycle after reset deasserts.
- Latency: 1 cycle; instruction accepted at edge N is on outputs with valid_o=1 from edge N.
- Hold: valid_o=1 & next_ready=0 -> all outputs stable, ready_o=0, inputs ignored.
- Back-to-back: valid_o=1, next_ready=1, prev_valid=1 -> new bundle replaces old at same edge, valid_o stays 1; full throughput one instruction/cycle.
- Drain: next_ready=1, prev_valid=0 -> valid_o falls to 0 next edge.
- flush: next edge valid_o=0 regardless of other inputs; incoming instruction dropped. Flush has priority over load and hold.
- rst mid-transfer: same as reset; held bundle lost.

## Test plan
- Reset then prev_valid=1, inst=0x00500093, pc=0x80000000, next_ready=1 -> one cycle later valid_o=1, rd_o=1, rs1_o=0, imm_o=5, alu_op_o=ADD, alu_src_imm_o=1, rd_we_o=1, pc_o=0x80000000.
- inst=0x123452B7 (lui x5) -> rd_o=5, imm_o=0x12345000, alu_op_o=PASS_IMM, rs1_o=0; inst=0x402081B3 (sub x3,x1,x2) -> rs1=1, rs2=2, rd=3, alu_op=SUB, alu_src_imm=0.
- inst=0x0020A423 (sw x2,8(x1)) -> is_store_o=1, imm_o=8, rd_we_o=0, funct3_o=2; inst=0xFE000EE3 (beq x0,x0,-4) -> is_branch_o=1, imm_o=0xFFFFFFFC, alu_op=SUB.
- Backpressure: load addi, hold next_ready=0 for 3 cycles while prev_valid=1 with 0x402081B3 -> outputs unchanged, ready_o=0; release -> sub appears the following cycle, no instruction lost or duplicated.
- flush asserted with valid_o=1 and prev_valid=1 -> next cycle valid_o=0; then inst=0x00000000 -> illegal_o=1, rd_we_o=0.

Source files
------------

// File: rtl/idu_decode_stage.sv
//------------------------------------------------------------------------------
// Module  : idu_decode_stage
// Brief   : RV32I decode stage with a single-entry, pass-through output register.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module idu_decode_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_valid,
    output logic              ready_o,
    input  logic [DATA_W-1:0] inst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              valid_o,
    input  logic              next_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [3:0]        alu_op_o,
    output logic [2:0]        funct3_o,
    output logic              rd_we_o,
    output logic              alu_src_imm_o,
    output logic              is_load_o,
    output logic              is_store_o,
    output logic              is_branch_o,
    output logic              is_jal_o,
    output logic              is_jalr_o,
    output logic              is_auipc_o,
    output logic              is_system_o,
    output logic              illegal_o
);

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_SLL  = 4'd2;
    localparam logic [3:0] c_ALU_SLT  = 4'd3;
    localparam logic [3:0] c_ALU_SLTU = 4'd4;
    localparam logic [3:0] c_ALU_XOR  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_OR   = 4'd8;
    localparam logic [3:0] c_ALU_AND  = 4'd9;
    localparam logic [3:0] c_ALU_PASS = 4'd10;

    localparam logic [6:0] c_F7_ZERO = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [DATA_W-1:0] imm;
        logic [3:0]        alu_op;
        logic [2:0]        funct3;
        logic              rd_we;
        logic              alu_src_imm;
        logic              is_load;
        logic              is_store;
        logic              is_branch;
        logic              is_jal;
        logic              is_jalr;
        logic              is_auipc;
        logic              is_system;
        logic              illegal;
    } bundle_t;

    bundle_t bundle_d;
    bundle_t bundle_q;
    logic    valid_q;

    logic [31:0] w_i;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm;
    logic [3:0]  w_alu;
    logic        w_rs1_use;
    logic        w_rs2_use;
    logic        w_rd_use;
    logic        w_src_imm;
    logic        w_legal;
    logic [6:0]  w_cls;
    logic        w_rd_we;
    logic        w_load;

    assign w_i   = inst[31:0];
    assign w_opc = w_i[6:0];
    assign w_f3  = w_i[14:12];
    assign w_f7  = w_i[31:25];

    assign w_imm_i = {{20{w_i[31]}}, w_i[31:20]};
    assign w_imm_s = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
    assign w_imm_b = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
    assign w_imm_u = {w_i[31:12], 12'h000};
    assign w_imm_j = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};

    // w_cls order: load, store, branch, jal, jalr, auipc, system
    always_comb begin
        w_rs1_use = 1'b0;
        w_rs2_use = 1'b0;
        w_rd_use  = 1'b0;
        w_src_imm = 1'b0;
        w_alu     = c_ALU_ADD;
        w_imm     = 32'h0;
        w_legal   = 1'b1;
        w_cls     = 7'b0;
        case (w_opc)
            c_OPC_LUI: begin
                w_rd_use = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_u; w_alu = c_ALU_PASS;
            end
            c_OPC_AUIPC: begin
                w_rd_use = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_u; w_cls = 7'b0000010;
            end
            c_OPC_JAL: begin
                w_rd_use = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_j; w_cls = 7'b0001000;
            end
            c_OPC_JALR: begin
                w_rs1_use = 1'b1; w_rd_use = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_i;
                w_cls     = 7'b0000100;
                w_legal   = (w_f3 == 3'b000);
            end
            c_OPC_BRANCH: begin
                w_rs1_use = 1'b1; w_rs2_use = 1'b1; w_imm = w_imm_b; w_alu = c_ALU_SUB;
                w_cls     = 7'b0010000;
                w_legal   = (w_f3 != 3'b010) && (w_f3 != 3'b011);
            end
            c_OPC_LOAD: begin
                w_rs1_use = 1'b1; w_rd_use = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_i;
                w_cls     = 7'b1000000;
                w_legal   = (w_f3 != 3'b011) && (w_f3 < 3'b110);
            end
            c_OPC_STORE: begin
                w_rs1_use = 1'b1; w_rs2_use = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_s;
                w_cls     = 7'b0100000;
                w_legal   = (w_f3 < 3'b011);
            end
            c_OPC_OPIMM: begin
                w_rs1_use = 1'b1; w_rd_use = 1'b1; w_src_imm = 1'b1; w_imm = w_imm_i;
                w_alu     = alu_from_f3(w_f3, 1'b0, w_i[30]);
                if ((w_f3 == 3'b001) || (w_f3 == 3'b101))
                    w_legal = (w_f7 == c_F7_ZERO) || (w_f7 == c_F7_ALT);
            end
            c_OPC_OP: begin
                w_rs1_use = 1'b1; w_rs2_use = 1'b1; w_rd_use = 1'b1;
                w_alu     = alu_from_f3(w_f3, w_i[30], w_i[30]);
                // Alternate funct7 is only defined for SUB and SRA.
                w_legal   = (w_f7 == c_F7_ZERO) ||
                            ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            c_OPC_FENCE: begin
                w_legal = 1'b1;
            end
            c_OPC_SYSTEM: begin
                w_imm    = w_imm_i;
                w_rd_use = (w_f3 != 3'b000);
                w_cls    = 7'b0000001;
            end
            default: w_legal = 1'b0;
        endcase
        if (w_i[1:0] != 2'b11)
            w_legal = 1'b0;
    end

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3,
                                               input logic       sub_sel,
                                               input logic       sra_sel);
        case (f3)
            3'b000:  return sub_sel ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  return c_ALU_SLL;
            3'b010:  return c_ALU_SLT;
            3'b011:  return c_ALU_SLTU;
            3'b100:  return c_ALU_XOR;
            3'b101:  return sra_sel ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  return c_ALU_OR;
            default: return c_ALU_AND;
        endcase
    endfunction

    assign w_rd_we = w_legal && w_rd_use && (w_i[11:7] != 5'd0);

    // Illegal words keep only pc/inst/funct3 so downstream sees a clean bubble-like bundle.
    always_comb begin
        bundle_d             = '0;
        bundle_d.pc          = pc;
        bundle_d.inst        = inst;
        bundle_d.funct3      = w_f3;
        bundle_d.illegal     = !w_legal;
        if (w_legal) begin
            bundle_d.rs1         = w_rs1_use ? w_i[19:15] : 5'd0;
            bundle_d.rs2         = w_rs2_use ? w_i[24:20] : 5'd0;
            bundle_d.rd          = w_rd_we ? w_i[11:7] : 5'd0;
            bundle_d.imm         = DATA_W'($signed(w_imm));
            bundle_d.alu_op      = w_alu;
            bundle_d.rd_we       = w_rd_we;
            bundle_d.alu_src_imm = w_src_imm;
            {bundle_d.is_load, bundle_d.is_store, bundle_d.is_branch, bundle_d.is_jal,
             bundle_d.is_jalr, bundle_d.is_auipc, bundle_d.is_system} = w_cls;
        end
    end

    assign ready_o = !valid_q || next_ready;
    assign w_load  = prev_valid && ready_o && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (w_load) begin
            valid_q  <= 1'b1;
            bundle_q <= bundle_d;
        end else if (next_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o       = valid_q;
    assign pc_o          = bundle_q.pc;
    assign inst_o        = bundle_q.inst;
    assign rs1_o         = bundle_q.rs1;
    assign rs2_o         = bundle_q.rs2;
    assign rd_o          = bundle_q.rd;
    assign imm_o         = bundle_q.imm;
    assign alu_op_o      = bundle_q.alu_op;
    assign funct3_o      = bundle_q.funct3;
    assign rd_we_o       = bundle_q.rd_we;
    assign alu_src_imm_o = bundle_q.alu_src_imm;
    assign is_load_o     = bundle_q.is_load;
    assign is_store_o    = bundle_q.is_store;
    assign is_branch_o   = bundle_q.is_branch;
    assign is_jal_o      = bundle_q.is_jal;
    assign is_jalr_o     = bundle_q.is_jalr;
    assign is_auipc_o    = bundle_q.is_auipc;
    assign is_system_o   = bundle_q.is_system;
    assign illegal_o     = bundle_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_idu_decode_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_idu_decode_stage
// Brief   : Table-driven, scoreboarded bench for idu_decode_stage.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_idu_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        rd_we;
        logic        alu_src_imm;
        logic [7:0]  cls;   // load, store, branch, jal, jalr, auipc, system, illegal
    } bundle_t;

    localparam int NV = 22;

    logic        clk = 1'b0;
    logic        rst, prev_valid, flush, next_ready;
    logic        ready_o, valid_o;
    logic [31:0] inst, pc;
    logic [31:0] pc_o, inst_o, imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [3:0]  alu_op_o;
    logic [2:0]  funct3_o;
    logic        rd_we_o, alu_src_imm_o, is_load_o, is_store_o, is_branch_o;
    logic        is_jal_o, is_jalr_o, is_auipc_o, is_system_o, illegal_o;

    idu_decode_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(ready_o),
        .inst(inst), .pc(pc), .flush(flush), .valid_o(valid_o), .next_ready(next_ready),
        .pc_o(pc_o), .inst_o(inst_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .imm_o(imm_o), .alu_op_o(alu_op_o), .funct3_o(funct3_o), .rd_we_o(rd_we_o),
        .alu_src_imm_o(alu_src_imm_o), .is_load_o(is_load_o), .is_store_o(is_store_o),
        .is_branch_o(is_branch_o), .is_jal_o(is_jal_o), .is_jalr_o(is_jalr_o),
        .is_auipc_o(is_auipc_o), .is_system_o(is_system_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    bundle_t act;
    assign act = {pc_o, inst_o, rs1_o, rs2_o, rd_o, imm_o, alu_op_o, funct3_o, rd_we_o,
                  alu_src_imm_o, is_load_o, is_store_o, is_branch_o, is_jal_o, is_jalr_o,
                  is_auipc_o, is_system_o, illegal_o};

    int      n_tests = 0;
    int      n_fail  = 0;
    bundle_t vecs[NV];
    bundle_t sb[$];
    logic    m_valid;
    bundle_t m_last;

    function automatic bundle_t mk(input logic [31:0] in, input logic [4:0] r1,
                                   input logic [4:0] r2, input logic [4:0] rd,
                                   input logic [31:0] im, input logic [3:0] op,
                                   input logic [2:0] f3, input logic we, input logic src,
                                   input logic [7:0] cls);
        return {32'h0, in, r1, r2, rd, im, op, f3, we, src, cls};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One clock: drive at negedge, check ready, predict, check the registered bundle after the edge.
    task automatic tick(input string name, input logic pv, input logic [31:0] in,
                        input logic [31:0] p, input logic fl, input logic nr,
                        input bundle_t expb);
        logic exp_ready, load, consumed;
        @(negedge clk);
        prev_valid = pv; inst = in; pc = p; flush = fl; next_ready = nr;
        #1;
        exp_ready = !m_valid || nr;
        chk({name, " ready_o"}, 128'(ready_o), 128'(exp_ready));
        load     = pv && exp_ready && !fl;
        consumed = m_valid && nr;
        if (load) sb.push_back(expb);
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            m_valid = 1'b0;
        end else begin
            if (consumed && sb.size() > 1) void'(sb.pop_front());
            else if (consumed && !load && sb.size() > 0) void'(sb.pop_front());
            if (load) begin
                m_valid = 1'b1;
                m_last  = expb;
            end else if (consumed) begin
                m_valid = 1'b0;
            end
        end
        chk({name, " valid_o"}, 128'(valid_o), 128'(m_valid));
        if (m_valid && sb.size() > 0) chk({name, " bundle"}, act, sb[0]);
        else                          chk({name, " held fields"}, act, m_last);
    endtask

    task automatic do_reset(input string name, input logic pv, input logic [31:0] in);
        @(negedge clk);
        rst = 1'b1; prev_valid = pv; inst = in; flush = 1'b0; next_ready = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        m_valid = 1'b0;
        m_last  = '0;
        chk({name, " valid_o"}, 128'(valid_o), 128'(1'b0));
        chk({name, " outputs"}, act, 128'(0));
        @(negedge clk);
        rst = 1'b0; prev_valid = 1'b0; flush = 1'b0;
    endtask

    function automatic bundle_t at_pc(input int idx, input logic [31:0] p);
        bundle_t b;
        b    = vecs[idx];
        b.pc = p;
        return b;
    endfunction

    initial begin
        //                inst          rs1 rs2 rd  imm            alu   f3  we src cls
        vecs[0]  = mk(32'h00500093, 5'd0, 5'd0, 5'd1, 32'd5,        4'd0, 3'd0, 1, 1, 8'b0000_0000);
        vecs[1]  = mk(32'h123452B7, 5'd0, 5'd0, 5'd5, 32'h12345000, 4'd10,3'd5, 1, 1, 8'b0000_0000);
        vecs[2]  = mk(32'h402081B3, 5'd1, 5'd2, 5'd3, 32'd0,        4'd1, 3'd0, 1, 0, 8'b0000_0000);
        vecs[3]  = mk(32'h0020A423, 5'd1, 5'd2, 5'd0, 32'd8,        4'd0, 3'd2, 0, 1, 8'b0100_0000);
        vecs[4]  = mk(32'hFE000EE3, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 4'd1, 3'd0, 0, 0, 8'b0010_0000);
        vecs[5]  = mk(32'h008000EF, 5'd0, 5'd0, 5'd1, 32'd8,        4'd0, 3'd0, 1, 1, 8'b0001_0000);
        vecs[6]  = mk(32'h00008067, 5'd1, 5'd0, 5'd0, 32'd0,        4'd0, 3'd0, 0, 1, 8'b0000_1000);
        vecs[7]  = mk(32'h00001117, 5'd0, 5'd0, 5'd2, 32'h00001000, 4'd0, 3'd1, 1, 1, 8'b0000_0100);
        vecs[8]  = mk(32'hFFC12183, 5'd2, 5'd0, 5'd3, 32'hFFFFFFFC, 4'd0, 3'd2, 1, 1, 8'b1000_0000);
        vecs[9]  = mk(32'h4010D093, 5'd1, 5'd0, 5'd1, 32'h00000401, 4'd7, 3'd5, 1, 1, 8'b0000_0000);
        vecs[10] = mk(32'h0020E1B3, 5'd1, 5'd2, 5'd3, 32'd0,        4'd8, 3'd6, 1, 0, 8'b0000_0000);
        vecs[11] = mk(32'h00000013, 5'd0, 5'd0, 5'd0, 32'd0,        4'd0, 3'd0, 0, 1, 8'b0000_0000);
        vecs[12] = mk(32'h300092F3, 5'd0, 5'd0, 5'd5, 32'h00000300, 4'd0, 3'd1, 1, 0, 8'b0000_0010);
        vecs[13] = mk(32'h00000073, 5'd0, 5'd0, 5'd0, 32'd0,        4'd0, 3'd0, 0, 0, 8'b0000_0010);
        vecs[14] = mk(32'h0FF0000F, 5'd0, 5'd0, 5'd0, 32'd0,        4'd0, 3'd0, 0, 0, 8'b0000_0000);
        vecs[15] = mk(32'h00000000, 5'd0, 5'd0, 5'd0, 32'd0,        4'd0, 3'd0, 0, 0, 8'b0000_0001);
        vecs[16] = mk(32'h02009093, 5'd0, 5'd0, 5'd0, 32'd0,        4'd0, 3'd1, 0, 0, 8'b0000_0001);
        vecs[17] = mk(32'h0000A063, 5'd0, 5'd0, 5'd0, 32'd0,        4'd0, 3'd2, 0, 0, 8'b0000_0001);
        vecs[18] = mk(32'h00500092, 5'd0, 5'd0, 5'd0, 32'd0,        4'd0, 3'd0, 0, 0, 8'b0000_0001);
        vecs[19] = mk(32'h00009067, 5'd0, 5'd0, 5'd0, 32'd0,        4'd0, 3'd1, 0, 0, 8'b0000_0001);
        vecs[20] = mk(32'h0020B423, 5'd0, 5'd0, 5'd0, 32'd0,        4'd0, 3'd3, 0, 0, 8'b0000_0001);
        vecs[21] = mk(32'h0000E083, 5'd0, 5'd0, 5'd0, 32'd0,        4'd0, 3'd6, 0, 0, 8'b0000_0001);

        rst = 1'b1; prev_valid = 1'b0; flush = 1'b0; next_ready = 1'b0;
        inst = 32'h0; pc = 32'h0;
        m_valid = 1'b0; m_last = '0;
        repeat (3) @(posedge clk);
        do_reset("reset", 1'b0, 32'h0);
        tick("idle after reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0);

        // Full-throughput stream: one table entry per cycle.
        for (int i = 0; i < NV; i++) begin
            logic [31:0] p;
            p = 32'h8000_0000 + 32'(4 * i);
            tick($sformatf("vec%0d", i), 1'b1, vecs[i].inst, p, 1'b0, 1'b1, at_pc(i, p));
        end
        tick("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0);

        // Backpressure: addi held while sub waits, then sub accepted exactly once.
        tick("bp load addi", 1'b1, vecs[0].inst, 32'h100, 1'b0, 1'b1, at_pc(0, 32'h100));
        for (int k = 0; k < 3; k++)
            tick($sformatf("bp hold%0d", k), 1'b1, vecs[2].inst, 32'h104, 1'b0, 1'b0, at_pc(2, 32'h104));
        tick("bp release", 1'b1, vecs[2].inst, 32'h104, 1'b0, 1'b1, at_pc(2, 32'h104));
        tick("bp drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0);

        // Flush drops both the held and the incoming instruction.
        tick("fl load addi", 1'b1, vecs[0].inst, 32'h200, 1'b0, 1'b1, at_pc(0, 32'h200));
        tick("fl flush held", 1'b1, vecs[2].inst, 32'h204, 1'b1, 1'b0, at_pc(2, 32'h204));
        tick("fl illegal", 1'b1, 32'h0, 32'h208, 1'b0, 1'b1, at_pc(15, 32'h208));
        tick("fl flush ready", 1'b1, vecs[1].inst, 32'h20C, 1'b1, 1'b1, at_pc(1, 32'h20C));
        tick("fl after", 1'b1, vecs[3].inst, 32'h210, 1'b0, 1'b1, at_pc(3, 32'h210));

        // Reset while a bundle is being held.
        tick("mr load", 1'b1, vecs[5].inst, 32'h300, 1'b0, 1'b1, at_pc(5, 32'h300));
        tick("mr hold", 1'b1, vecs[8].inst, 32'h304, 1'b0, 1'b0, at_pc(8, 32'h304));
        do_reset("mid reset", 1'b1, vecs[8].inst);
        tick("mr resume", 1'b1, vecs[8].inst, 32'h304, 1'b0, 1'b1, at_pc(8, 32'h304));
        tick("mr drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
